// File: rtl/control_sequencer_pkg.sv
// Shared opcode, state and width definitions for the control sequencer.
package control_sequencer_pkg;

  localparam int unsigned INSTR_W = 12;

  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JNZ  = 4'hA;
  localparam logic [3:0] OP_NOP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hC;

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_DECODE  = 2'd1;
  localparam logic [1:0] S_EXECUTE = 2'd2;
  localparam logic [1:0] S_HALTED  = 2'd3;

  localparam logic [INSTR_W-1:0] IR_RESET = 12'h0B0;

  // Opcodes 0x0..0x7 are ALU operations; bit 3 set means control/NOP.
  function automatic logic is_alu(input logic [3:0] opcode);
    return !opcode[3];
  endfunction

endpackage

// File: rtl/control_sequencer_program_counter.sv
// Modulo-2^PC_W program counter with clear, load and increment.
module control_sequencer_program_counter #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_value,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;

  // Clear has priority so a reset during EXECUTE blocks the pc update.
  always_ff @(posedge clk) begin
    if (clear) begin
      pc_q <= '0;
    end else if (load) begin
      pc_q <= load_value;
    end else if (inc) begin
      pc_q <= pc_q + PC_W'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer driving operation_block from a synchronous program ROM.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic [7:0]         acc_value,
  output logic [2:0]         operation_code,
  output logic               aku_enable,
  output logic [7:0]         in_b,
  output logic               halted,
  output logic [PC_W-1:0]    pc
);

  logic [1:0]         state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  logic [3:0]         opcode;
  logic [7:0]         imm;
  logic               pc_load, pc_inc;

  assign opcode = ir_q[11:8];
  assign imm    = ir_q[7:0];

  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_JMP: pc_load = 1'b1;
          OP_JZ: begin
            pc_load = (acc_value == 8'd0);
            pc_inc  = (acc_value != 8'd0);
          end
          OP_JNZ: begin
            pc_load = (acc_value != 8'd0);
            pc_inc  = (acc_value == 8'd0);
          end
          OP_HALT: state_d = S_HALTED;
          OP_NOP:  pc_inc = 1'b1;
          default: pc_inc = 1'b1;
        endcase
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= IR_RESET;
    end else begin
      state_q <= state_d;
      // ROM data for the address presented in FETCH is valid during DECODE.
      if (state_q == S_DECODE) begin
        ir_q <= instr_data;
      end
    end
  end

  control_sequencer_program_counter #(
    .PC_W(PC_W)
  ) u_program_counter (
    .clk       (clk),
    .clear     (rst),
    .load      (pc_load),
    .inc       (pc_inc),
    .load_value(imm[PC_W-1:0]),
    .pc        (pc)
  );

  assign instr_addr     = pc;
  assign operation_code = ir_q[10:8];
  assign in_b           = imm;
  assign aku_enable     = (state_q == S_EXECUTE) && is_alu(opcode);
  assign halted         = (state_q == S_HALTED);

endmodule
